// File: rtl/mux_n_pipe_pkg.sv
// Shared definitions for the N:1 pipelined word selector: select-width
// derivation, buffer-entry layout and the buffer occupancy encoding.
package mux_n_pipe_pkg;

  // Select width for an N-way choice; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // A buffered entry is packed as {err, sel, data}, MSB to LSB.
  function automatic int entry_width(input int width, input int sel_w);
    return width + sel_w + 1;
  endfunction

  // Buffer occupancy: nothing held, output reg only, output reg plus skid reg.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd3
  } buf_state_e;

endpackage

// File: rtl/mux_n_comb.sv
// Combinational N:1 word select. A select beyond the last source yields a
// zero word with err set.
module mux_n_comb
  import mux_n_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N_IN  = 4,
  localparam int SEL_W = sel_width(N_IN)
) (
  input  logic [N_IN*WIDTH-1:0] data,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      word,
  output logic                  err
);

  // Scan every legal source; an unmatched select leaves the zero/err defaults.
  always_comb begin
    word = '0;
    err  = 1'b1;
    for (int k = 0; k < N_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        word = data[k*WIDTH +: WIDTH];
        err  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_n_pipe.sv
// N:1 word selector with a registered, back-pressurable output stage made of
// an output register plus one skid register.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high (valid_i & ready_o upstream, valid_o & ready_i downstream).
// valid_o and its payload do not change while valid_o=1 and ready_i=0.
// ready_o is a decode of registered state only, so it never depends
// combinationally on ready_i or valid_i.
module mux_n_pipe
  import mux_n_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N_IN  = 4,
  localparam int SEL_W = sel_width(N_IN)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [N_IN*WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0]      sel_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [WIDTH-1:0]      data_o,
  output logic [SEL_W-1:0]      sel_o,
  output logic                  err_o
);

  localparam int ENTRY_W = entry_width(WIDTH, SEL_W);

  buf_state_e         state;
  buf_state_e         state_next;
  logic [ENTRY_W-1:0] in_entry;
  logic [ENTRY_W-1:0] out_entry;
  logic [ENTRY_W-1:0] skid_entry;
  logic [WIDTH-1:0]   sel_word;
  logic               sel_err;
  logic               in_fire;
  logic               out_fire;
  logic               load_out;
  logic               load_skid;
  logic               skid_to_out;

  mux_n_comb #(
    .WIDTH (WIDTH),
    .N_IN  (N_IN)
  ) u_mux (
    .data (data_i),
    .sel  (sel_i),
    .word (sel_word),
    .err  (sel_err)
  );

  // The error flag and select travel with the word they produced.
  assign in_entry = {sel_err, sel_i, sel_word};

  assign ready_o  = (state != BUF_TWO);
  assign valid_o  = (state != BUF_EMPTY);
  assign in_fire  = valid_i & ready_o;
  assign out_fire = valid_o & ready_i;

  assign {err_o, sel_o, data_o} = out_entry;

  // Occupancy register; reset and flush both empty the stage.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      state <= BUF_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Next occupancy and which register loads from where.
  always_comb begin
    state_next  = state;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    unique case (state)
      BUF_EMPTY: begin
        if (in_fire) begin
          state_next = BUF_ONE;
          load_out   = 1'b1;
        end
      end
      BUF_ONE: begin
        if (out_fire && in_fire) begin
          // Pass-through: the output reg reloads in place, valid_o stays high.
          load_out = 1'b1;
        end else if (out_fire) begin
          state_next = BUF_EMPTY;
        end else if (in_fire) begin
          // Downstream stalled while a new word arrived: park it in the skid.
          state_next = BUF_TWO;
          load_skid  = 1'b1;
        end
      end
      BUF_TWO: begin
        // ready_o is low here, so only the skid-to-output move is possible.
        if (out_fire) begin
          state_next  = BUF_ONE;
          skid_to_out = 1'b1;
        end
      end
      default: begin
        state_next = BUF_EMPTY;
      end
    endcase
  end

  // Payload registers; the output reg holds its value when nothing loads.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      out_entry  <= '0;
      skid_entry <= '0;
    end else begin
      if (load_out) begin
        out_entry <= in_entry;
      end else if (skid_to_out) begin
        out_entry <= skid_entry;
      end
      if (load_skid) begin
        skid_entry <= in_entry;
      end
    end
  end

endmodule

// File: tb/tb_mux_n_pipe.sv
// Bench for mux_n_pipe: three instances (32-bit/4-way, 8-bit/3-way,
// 8-bit/5-way) sharing clock, reset and flush. Inputs change 2 time units
// after the rising edge; handshakes are observed at the falling edge.
module tb_mux_n_pipe;

  logic         clk;
  logic         rst;
  logic         flush;
  logic [2:0]   vin;
  logic [2:0]   rdy_in;
  logic [2:0]   rdy_out;
  logic [2:0]   vout;
  logic [2:0]   errs;

  logic [127:0] a_data;
  logic [1:0]   a_sel;
  logic [31:0]  a_do;
  logic [1:0]   a_so;
  logic [23:0]  b_data;
  logic [1:0]   b_sel;
  logic [7:0]   b_do;
  logic [1:0]   b_so;
  logic [39:0]  c_data;
  logic [2:0]   c_sel;
  logic [7:0]   c_do;
  logic [2:0]   c_so;

  // Common {err, sel[3:0], data[31:0]} view of each instance.
  logic [36:0]  act_w  [3];
  logic [36:0]  in_exp [3];

  int checks = 0;
  int errors = 0;

  mux_n_pipe #(.WIDTH(32), .N_IN(4)) dut_a (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(vin[0]), .ready_o(rdy_out[0]),
    .data_i(a_data), .sel_i(a_sel), .valid_o(vout[0]), .ready_i(rdy_in[0]),
    .data_o(a_do), .sel_o(a_so), .err_o(errs[0])
  );

  mux_n_pipe #(.WIDTH(8), .N_IN(3)) dut_b (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(vin[1]), .ready_o(rdy_out[1]),
    .data_i(b_data), .sel_i(b_sel), .valid_o(vout[1]), .ready_i(rdy_in[1]),
    .data_o(b_do), .sel_o(b_so), .err_o(errs[1])
  );

  mux_n_pipe #(.WIDTH(8), .N_IN(5)) dut_c (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(vin[2]), .ready_o(rdy_out[2]),
    .data_i(c_data), .sel_i(c_sel), .valid_o(vout[2]), .ready_i(rdy_in[2]),
    .data_o(c_do), .sel_o(c_so), .err_o(errs[2])
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [36:0] model(input logic [127:0] d, input int s, input int n, input int w);
    logic [31:0] word;
    word = '0;
    if (s < n) begin
      for (int b = 0; b < w; b++) word[b] = d[s*w + b];
    end
    return {(s >= n), 4'(s), word};
  endfunction

  always_comb begin
    act_w[0]  = {errs[0], 2'b00, a_so, a_do};
    act_w[1]  = {errs[1], 2'b00, b_so, 24'h0, b_do};
    act_w[2]  = {errs[2], 1'b0, c_so, 24'h0, c_do};
    in_exp[0] = model(128'(a_data), int'(a_sel), 4, 32);
    in_exp[1] = model(128'(b_data), int'(b_sel), 3, 8);
    in_exp[2] = model(128'(c_data), int'(c_sel), 5, 8);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboards ----------------
  for (genvar g = 0; g < 3; g++) begin : sb
    logic [36:0] exp_q[$];
    logic        stalled = 1'b0;
    logic [36:0] held    = '0;

    // Input side: every accepted word predicts one output; reset/flush discard.
    always @(negedge clk) begin
      if (rst || flush) exp_q.delete();
      else if (vin[g] && rdy_out[g]) exp_q.push_back(in_exp[g]);
    end

    // Output side: compare each delivered word and check stall stability.
    always @(negedge clk) begin
      #1;
      if (stalled) begin
        check($sformatf("stall_valid%0d", g), 64'(vout[g]), 64'd1);
        check($sformatf("stall_hold%0d", g), 64'(act_w[g]), 64'(held));
      end
      if (!(rst || flush) && vout[g] && rdy_in[g]) begin
        if (exp_q.size() == 0) begin
          check($sformatf("unexpected_out%0d", g), 64'(act_w[g]), 64'd0 - 64'd1);
        end else begin
          check($sformatf("sb_out%0d", g), 64'(act_w[g]), 64'(exp_q.pop_front()));
        end
      end
      if (!(rst || flush) && vout[g] && !rdy_in[g]) begin
        stalled <= 1'b1;
        held    <= act_w[g];
      end else begin
        stalled <= 1'b0;
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_idle(input int k, input string tag);
    check({tag, "_valid"}, 64'(vout[k]), 64'd0);
    check({tag, "_ready"}, 64'(rdy_out[k]), 64'd1);
    check({tag, "_data"}, 64'(act_w[k]), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic        acc;
    logic [31:0] t1_exp [4];
    logic [1:0]  t3_sel [5];
    t1_exp = '{32'hAAAA0000, 32'hBBBB0001, 32'hCCCC0002, 32'hDDDD0003};
    t3_sel = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};

    rst = 1'b1; flush = 1'b0; vin = '0; rdy_in = 3'b111;
    a_data = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    a_sel = '0; b_data = 24'h332211; b_sel = '0; c_data = '0; c_sel = '0;
    acc = 1'b0;

    // Reset state of every instance.
    tick(); tick();
    rst = 1'b0;
    check_idle(0, "rst_a");
    check_idle(1, "rst_b");
    check_idle(2, "rst_c");

    // Streaming with ready_i=1: one cycle latency, one word per cycle.
    vin[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_sel = 2'(i);
      tick();
      check("t1_valid", 64'(vout[0]), 64'd1);
      check("t1_data", 64'(a_do), 64'(t1_exp[i]));
      check("t1_sel", 64'(a_so), 64'(i));
    end
    vin[0] = 1'b0;
    tick();
    check("t1_drained", 64'(vout[0]), 64'd0);
    check("t1_hold", 64'(a_do), 64'hDDDD0003);

    // Back-pressure: two accepted, third held off, then released in order.
    rdy_in[0] = 1'b0; vin[0] = 1'b1; a_sel = 2'd1;
    tick();
    check("t2_e1_ready", 64'(rdy_out[0]), 64'd1);
    check("t2_e1_data", 64'(a_do), 64'hBBBB0001);
    a_sel = 2'd2;
    tick();
    check("t2_e2_ready", 64'(rdy_out[0]), 64'd0);
    check("t2_e2_data", 64'(a_do), 64'hBBBB0001);
    a_sel = 2'd3;
    tick();
    check("t2_e3_ready", 64'(rdy_out[0]), 64'd0);
    check("t2_e3_data", 64'(a_do), 64'hBBBB0001);
    rdy_in[0] = 1'b1;
    tick();
    check("t2_e4_data", 64'(a_do), 64'hCCCC0002);
    check("t2_e4_ready", 64'(rdy_out[0]), 64'd1);
    tick();
    check("t2_e5_data", 64'(a_do), 64'hDDDD0003);
    check("t2_e5_valid", 64'(vout[0]), 64'd1);
    vin[0] = 1'b0;
    tick();
    check("t2_drained", 64'(vout[0]), 64'd0);

    // Simultaneous handshakes: output reloads every cycle, valid stays high.
    vin[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_sel = t3_sel[i];
      tick();
      check("t3_valid", 64'(vout[0]), 64'd1);
      check("t3_data", 64'(a_do), 64'(t1_exp[t3_sel[i]]));
    end
    vin[0] = 1'b0;
    tick();

    // Out-of-range select on the 3-way instance.
    vin[1] = 1'b1; b_sel = 2'd3;
    tick();
    check("t4_oor_data", 64'(b_do), 64'd0);
    check("t4_oor_err", 64'(errs[1]), 64'd1);
    check("t4_oor_sel", 64'(b_so), 64'd3);
    b_sel = 2'd2;
    tick();
    check("t4_top_data", 64'(b_do), 64'h33);
    check("t4_top_err", 64'(errs[1]), 64'd0);
    b_sel = 2'd0;
    tick();
    check("t4_zero_data", 64'(b_do), 64'h11);
    vin[1] = 1'b0;
    tick();

    // Flush with the skid full, then flush against a live handshake.
    rdy_in[0] = 1'b0; vin[0] = 1'b1; a_sel = 2'd0;
    tick();
    a_sel = 2'd1;
    tick();
    check("t5_skid_full", 64'(rdy_out[0]), 64'd0);
    flush = 1'b1; a_sel = 2'd2;
    tick();
    check_idle(0, "t5_flush");
    check("t5_flush_err", 64'(errs[0]), 64'd0);
    a_sel = 2'd3;
    tick();
    check("t5_flush_wins", 64'(vout[0]), 64'd0);
    flush = 1'b0; vin[0] = 1'b0;
    tick();
    check("t5_not_taken", 64'(vout[0]), 64'd0);

    // Reset mid-stream.
    rdy_in[0] = 1'b1; vin[0] = 1'b1; a_sel = 2'd0;
    tick();
    a_sel = 2'd1;
    tick();
    check("t5_stream", 64'(a_do), 64'hBBBB0001);
    rst = 1'b1; a_sel = 2'd2;
    tick();
    check_idle(0, "t5_rst");
    rst = 1'b0; vin[0] = 1'b0;
    tick();
    check("t5_after_rst", 64'(vout[0]), 64'd0);

    // Random valid/ready traffic on the 5-way instance; upstream holds
    // an offered word until it is taken.
    for (int i = 0; i < 10000; i++) begin
      if (!vin[2] || acc) begin
        vin[2]       = ($urandom_range(0, 3) != 0);
        c_sel        = 3'($urandom_range(0, 7));
        c_data[31:0] = $urandom;
        c_data[39:32] = 8'($urandom_range(0, 255));
      end
      rdy_in[2] = ($urandom_range(0, 2) != 0);
      acc = vin[2] && rdy_out[2];
      tick();
    end
    vin[2] = 1'b0; rdy_in[2] = 1'b1;
    for (int i = 0; i < 20 && (sb[2].exp_q.size() != 0 || vout[2]); i++) tick();
    tick();

    check("end_q_a", 64'(sb[0].exp_q.size()), 64'd0);
    check("end_q_b", 64'(sb[1].exp_q.size()), 64'd0);
    check("end_q_c", 64'(sb[2].exp_q.size()), 64'd0);
    check("end_idle_c", 64'(vout[2]), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
